// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the shared-ALU arbiter slice:
//   - DATA_W     : operand/result width (only 32 is supported)
//   - OP_*       : 3-bit ALU op encodings
//   - FLG_*      : bit positions inside the 4-bit {N, Z, C, V} flag vector
//   - buf_state_e: one-entry response buffer state
//   - alu_out_t  : combinational ALU result bundle
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [3:0]        flags;
    } alu_out_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// -----------------------------------------------------------------------------
// alu_share_arb_if
// Bundles the two requester channels and the response channel of
// alu_share_arb.
//   master : issue/writeback side (drives requests, consumes responses)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface alu_share_arb_if;
    import alu_arb_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_rr_arb2
// Two-way round-robin grant with a last_grant register.
//   clk, rst : clock, asynchronous active-high reset
//   valid0/1 : requester n presents an operation
//   accept   : the granted operation is taken this cycle
//   grant    : granted requester ID (combinational)
// On a conflict the requester not named by last_grant wins. last_grant
// resets to 1 so requester 0 wins the first conflict, and it only moves
// on an actual accept, so a stalled grant does not rotate.
// -----------------------------------------------------------------------------
module alu_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant
);

    logic last_grant;

    always_comb begin
        if (valid0 && valid1) grant = ~last_grant;
        else                  grant = valid1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Shares one 32-bit combinational ALU between two requesters. The granted
// operation is evaluated and registered into a one-entry response buffer
// with a valid/ready handshake (result one cycle after accept, one op per
// cycle while rsp_ready stays high).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_share_arb_if.slave
//              req0_*/req1_* valid/ready/a/b/op request channels
//              rsp_valid/ready/id/result/flags/err response channel
// Optional feature: define ALU_ARB_ILLEGAL_OP_EN to register rsp_err for
// ops 100, 110 and 111; otherwise rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    alu_share_arb_if.slave  bus
);

    function automatic alu_out_t alu_eval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [2:0]        op
    );
        alu_out_t          r;
        logic              use_sub;
        logic [DATA_W-1:0] bb;
        logic [DATA_W:0]   sum;
        // slt shares the subtract path; plain add is the only non-inverting case
        use_sub = (op != OP_ADD);
        bb      = use_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, use_sub};
        r       = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                r.result       = sum[DATA_W-1:0];
                r.flags[FLG_C] = sum[DATA_W];
                r.flags[FLG_V] = (a[DATA_W-1] == bb[DATA_W-1]) &&
                                 (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            // raw sign of the difference, deliberately without overflow correction
            OP_SLT:  r.result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1]};
            default: r.result = '0;
        endcase
        r.flags[FLG_Z] = (r.result == '0);
        r.flags[FLG_N] = r.result[DATA_W-1];
        return r;
    endfunction

    buf_state_e        state;
    logic              grant;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [2:0]        op_sel;
    alu_out_t          alu;

    alu_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    // a full buffer can take a new op in the same cycle it is drained
    assign can_accept     = (state == EMPTY) || (bus.rsp_valid && bus.rsp_ready);
    assign accept         = can_accept && (grant ? bus.req1_valid : bus.req0_valid);
    assign bus.req0_ready = can_accept && !grant;
    assign bus.req1_ready = can_accept &&  grant;

    assign op_a   = grant ? bus.req1_a  : bus.req0_a;
    assign op_b   = grant ? bus.req1_b  : bus.req0_b;
    assign op_sel = grant ? bus.req1_op : bus.req0_op;
    assign alu    = alu_eval(op_a, op_b, op_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state         <= FULL;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.rsp_ready && !accept) begin
                        state         <= EMPTY;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
            // fields only move on accept, so they hold stable under back-pressure
            if (accept) begin
                bus.rsp_id     <= grant;
                bus.rsp_result <= alu.result;
                bus.rsp_flags  <= alu.flags;
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic illegal;

    assign illegal = !(op_sel inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         bus.rsp_err <= 1'b0;
        else if (accept) bus.rsp_err <= illegal;
    end
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Self-checking bench for alu_share_arb: table of single-op vectors plus
// directed sequences for arbitration, back-pressure and mid-operation reset.
// Honours ALU_ARB_ILLEGAL_OP_EN for the expected rsp_err value.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;
    import alu_arb_pkg::*;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;   // {N, Z, C, V}
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // advance one cycle; inputs change and registered outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [31:0] res, input logic [3:0] flg);
        check({tag, " rsp_valid"},  32'(bus.rsp_valid), 32'(v));
        check({tag, " rsp_id"},     32'(bus.rsp_id),    32'(id));
        check({tag, " rsp_result"}, bus.rsp_result,     res);
        check({tag, " rsp_flags"},  32'(bus.rsp_flags), 32'(flg));
    endtask

    vec_t vecs[12];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 4'b1001, 1'b0};
        vecs[1]  = '{"sub_eq",     32'd5,         32'd5,         OP_SUB, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[2]  = '{"slt_3_5",    32'd3,         32'd5,         OP_SLT, 32'h0000_0001, 4'b0000, 1'b0};
        vecs[3]  = '{"slt_5_3",    32'd5,         32'd3,         OP_SLT, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[4]  = '{"and",        32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 32'hF000_F000, 4'b1000, 1'b0};
        vecs[5]  = '{"or",         32'h0000_0001, 32'h8000_0000, OP_OR,  32'h8000_0001, 4'b1000, 1'b0};
        vecs[6]  = '{"add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[7]  = '{"sub_borrow", 32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        vecs[8]  = '{"sub_ovf",    32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[9]  = '{"ill_111",    32'd5,         32'd3,         3'b111, 32'h0000_0000, 4'b0100, ERR_EN};
        vecs[10] = '{"ill_100",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'h0000_0000, 4'b0100, ERR_EN};
        vecs[11] = '{"slt_no_ovf", 32'h8000_0000, 32'h0000_0001, OP_SLT, 32'h0000_0000, 4'b0100, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive0(1'b0, '0, '0, OP_ADD);
        drive1(1'b0, '0, '0, OP_ADD);
        bus.rsp_ready = 1'b0;
        step();
        step();
        check_rsp("reset", 1'b0, 1'b0, 32'h0, 4'h0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // ---------------- conflict alternation after reset ----------------
        bus.rsp_ready = 1'b1;
        drive0(1'b1, 32'd1, 32'd1, OP_ADD);
        drive1(1'b1, 32'd2, 32'd2, OP_ADD);
        #1;
        check("conf1 req0_ready", 32'(bus.req0_ready), 32'h1);
        check("conf1 req1_ready", 32'(bus.req1_ready), 32'h0);
        step();
        check_rsp("conf1", 1'b1, 1'b0, 32'd2, 4'b0000);
        check("conf2 req0_ready", 32'(bus.req0_ready), 32'h0);
        check("conf2 req1_ready", 32'(bus.req1_ready), 32'h1);
        step();
        check_rsp("conf2", 1'b1, 1'b1, 32'd4, 4'b0000);
        check("conf3 req0_ready", 32'(bus.req0_ready), 32'h1);
        step();
        check_rsp("conf3", 1'b1, 1'b0, 32'd2, 4'b0000);
        drive0(1'b0, '0, '0, OP_ADD);
        drive1(1'b0, '0, '0, OP_ADD);
        step();
        check("conf drain rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // ---------------- table vectors via requester 0 ----------------
        for (int i = 0; i < 12; i++) begin
            drive0(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            check({vecs[i].name, " req0_ready"}, 32'(bus.req0_ready), 32'h1);
            step();
            drive0(1'b0, '0, '0, OP_ADD);
            check_rsp(vecs[i].name, 1'b1, 1'b0, vecs[i].exp_result, vecs[i].exp_flags);
            check({vecs[i].name, " rsp_err"}, 32'(bus.rsp_err), 32'(vecs[i].exp_err));
        end
        step();
        check("vec drain rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // ---------------- back-pressure ----------------
        // last_grant is now 0, so requester 1 wins the next conflict
        bus.rsp_ready = 1'b0;
        drive0(1'b1, 32'd10, 32'd20, OP_ADD);
        step();
        check_rsp("bp fill", 1'b1, 1'b0, 32'd30, 4'b0000);
        drive0(1'b1, 32'd100, 32'd200, OP_ADD);
        drive1(1'b1, 32'd7,   32'd8,   OP_ADD);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp req0_ready", 32'(bus.req0_ready), 32'h0);
            check("bp req1_ready", 32'(bus.req1_ready), 32'h0);
            step();
            check_rsp("bp hold", 1'b1, 1'b0, 32'd30, 4'b0000);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp release req1_ready", 32'(bus.req1_ready), 32'h1);
        step();
        check_rsp("bp drain+accept", 1'b1, 1'b1, 32'd15, 4'b0000);
        drive1(1'b0, '0, '0, OP_ADD);
        #1;
        check("bp next req0_ready", 32'(bus.req0_ready), 32'h1);
        step();
        check_rsp("bp req0 op", 1'b1, 1'b0, 32'd300, 4'b0000);
        drive0(1'b0, '0, '0, OP_ADD);
        step();
        check("bp drain rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // ---------------- reset mid-operation ----------------
        // req0 accept leaves last_grant=0; without reset req1 would win next
        bus.rsp_ready = 1'b0;
        drive0(1'b1, 32'h1234, 32'h1, OP_ADD);
        step();
        check_rsp("mid fill", 1'b1, 1'b0, 32'h1235, 4'b0000);
        drive1(1'b1, 32'd9, 32'd9, OP_SUB);
        #2;
        rst = 1'b1;
        #1;
        check_rsp("mid reset", 1'b0, 1'b0, 32'h0, 4'h0);
        check("mid reset rsp_err", 32'(bus.rsp_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        drive0(1'b1, 32'd40, 32'd2, OP_ADD);
        drive1(1'b1, 32'd9,  32'd9, OP_SUB);
        #1;
        check("post-reset req0_ready", 32'(bus.req0_ready), 32'h1);
        check("post-reset req1_ready", 32'(bus.req1_ready), 32'h0);
        step();
        check_rsp("post-reset", 1'b1, 1'b0, 32'd42, 4'b0000);
        drive0(1'b0, '0, '0, OP_ADD);
        step();
        check_rsp("post-reset req1", 1'b1, 1'b1, 32'd0, 4'b0110);
        drive1(1'b0, '0, '0, OP_ADD);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

- Shares one 32-bit ALU between two independent requesters (e.g. integer pipe and address-generation unit).
- Arbitrates round-robin and evaluates the granted operation with the team's combinational ALU.
- Registers the result, flags and requester ID into a one-entry output buffer with valid/ready handshake.
- Sits between issue logic and writeback: one operation accepted and one result delivered per cycle, at most.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle (valid & ready).
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_op / req1_op  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal.
- rsp_valid  out  1  result buffer holds a result.
- rsp_ready  in  1  consumer takes the result (valid & ready).
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  DATA_W  ALU result.
- rsp_flags  out  4  {Negative, Zero, Carry, OverFlow}.
- rsp_err  out  1  illegal-op indication (only with ALU_ARB_ILLEGAL_OP_EN; otherwise tied 0).

## Operation
- Buffer FSM, two states:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without accept.
  - FULL stays FULL on drain with simultaneous accept.
- can_accept = EMPTY | (rsp_valid & rsp_ready).
- Grant:
  - one requester valid: it is granted.
  - both valid: the requester not named by last_grant is granted.
  - reqN_ready = can_accept & grant==N.
  - ready is combinational from valids, rsp_ready and state.
- last_grant updates to the granted ID on every accept only.
- Arithmetic uses a 33-bit sum:
  - add: A + B.
  - sub: A + ~B + 1.
- Result by op:
  - add/sub: sum[31:0].
  - and: A & B.
  - or: A | B.
  - slt: {31'b0, sum[31]} of the subtract, with no overflow correction.
- Carry = sum[32] for add/sub; 0 otherwise.
- OverFlow for add/sub = operand signs (B inverted for sub) agree and result sign differs; 0 otherwise.
- Zero = (result == 0).
- Negative = result[31].
- Illegal op: result 0, Zero=1, other flags 0. Still accepted and still consumes a grant.
- Requester must hold operands and op stable while valid & !ready. The block does not check this.

## Timing
- Latency: accept in cycle t gives rsp_valid in cycle t+1, with all response fields registered.
- Throughput: 1 op/cycle while rsp_ready is held high.
- Back-pressure: rsp_ready=0 with FULL forces both readies to 0. Response fields hold stable.
- Reset (asynchronous, any time including mid-handshake):
  - state EMPTY, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, rsp_err 0.
  - last_grant = 1, so requester 0 wins the first conflict.
  - a pending result is discarded.
- rsp_ready while EMPTY has no effect.

## Configuration
- ALU_ARB_ILLEGAL_OP_EN defined:
  - rsp_err is registered with the result and is 1 for ops 100, 110, 111.
  - the illegal op is still accepted and produces result 0, Zero=1.
- Undefined: no error logic; rsp_err is constant 0. Result and flags behaviour is unchanged.

## Structure
- Shared package alu_arb_pkg:
  - op encodings: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT.
  - flag bit indices: FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
  - buffer-state typedef {EMPTY, FULL}.
- Sub-module alu_rr_arb2: two-way round-robin grant and last_grant register.
- The ALU evaluation is a combinational function/instance inside the top.

## Test plan
- Single op: req0 add A=0x7FFFFFFF, B=1 → next cycle rsp_id=0, result=0x80000000, flags N=1 Z=0 C=0 V=1.
- Conflict after reset: both valid in the same cycle → req0 granted first, then req1, then req0 on continued conflict. Verifies alternation.
- Sub equal and slt:
  - sub 5-5 → result 0, Z=1, C=1, V=0.
  - slt 3,5 → result 1.
  - slt 5,3 → result 0.
- Back-pressure: rsp_ready=0 for 4 cycles while FULL → both readies 0, response fields stable. Release gives drain plus a same-cycle new accept, with no gap and no lost op.
- Reset mid-operation: assert rst while FULL with both requesters valid → rsp_valid 0 immediately. After release, first conflict grants req0.
- Illegal op 111:
  - with ALU_ARB_ILLEGAL_OP_EN: rsp_err=1, result 0, Z=1.
  - without the macro: rsp_err=0.
